serial_divider: RTL and testbench

- Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
- Responder side of the execute-stage enable/busy handshake. The execute stage raises i_md_en with operands and funct3, then stalls while o_busy is high.
- Consumes operands and funct3 straight from the decode/execute operand bus; o_result feeds the execute result mux.

---
 rtl/serial_divider.sv | 167 ++++++++++++++++
 tb/tb_serial_divider.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_divider.sv
// ---------------------------------------------------------------------------
// serial_divider
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   It answers the execute stage's enable/busy handshake: the stage raises
//   i_md_en with its operands and holds them, and it stalls while o_busy is
//   high. All state changes on the falling edge of i_clk_n.
//
//   Ports:
//     i_clk_n   clock (falling-edge active)
//     i_rst     synchronous active-high reset
//     i_in_a    dividend (rs1)
//     i_in_b    divisor (rs2)
//     i_funct3  100 DIV, 101 DIVU, 110 REM, 111 REMU; bit 2 low = not a divide
//     i_md_en   operation request, held until o_busy drops
//     o_busy    combinational stall request
//     o_result  quotient or remainder, valid in the DONE cycle
//
//   Build option: define DIV_FAST_EN to finish divide-by-zero, signed
//   overflow and |a|<|b| in the start cycle. The default build always
//   iterates WIDTH times.
// ---------------------------------------------------------------------------
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk_n,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic [2:0]       i_funct3,
    input  logic             i_md_en,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_result
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             rem_sel_q, rem_sel_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;

    logic             start;
    logic             in_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_it, quo_it, rem_fix, quo_fix;
`ifdef DIV_FAST_EN
    logic             b_zero, ovf, small;
`endif

    always_comb begin
        start     = i_md_en & i_funct3[2];
        in_signed = ~i_funct3[0];
        a_neg     = in_signed & i_in_a[WIDTH-1];
        b_neg     = in_signed & i_in_b[WIDTH-1];
        a_abs     = a_neg ? -i_in_a : i_in_a;
        b_abs     = b_neg ? -i_in_b : i_in_b;

        // One restoring step: shift {rem,quo} left, subtract divisor if it fits.
        // The difference always fits in WIDTH bits because the result < divisor.
        shifted = {rem_q, quo_q[WIDTH-1]};
        ge      = shifted >= {1'b0, div_q};
        rem_it  = ge ? (shifted[WIDTH-1:0] - div_q) : shifted[WIDTH-1:0];
        quo_it  = {quo_q[WIDTH-2:0], ge};
        quo_fix = q_neg_q ? -quo_it : quo_it;
        rem_fix = r_neg_q ? -rem_it : rem_it;

`ifdef DIV_FAST_EN
        b_zero = (i_in_b == '0);
        ovf    = in_signed & (i_in_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&i_in_b);
        small  = (a_abs < b_abs);
`endif

        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        result_d  = result_q;
        rem_sel_d = rem_sel_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_sel_d = i_funct3[1];
                    // Divide by zero keeps the all-ones quotient unsigned.
                    q_neg_d   = (a_neg ^ b_neg) & (i_in_b != '0);
                    r_neg_d   = a_neg;
                    rem_d     = '0;
                    quo_d     = a_abs;
                    div_d     = b_abs;
                    cnt_d     = '0;
                    state_d   = S_RUN;
`ifdef DIV_FAST_EN
                    if (b_zero) begin
                        result_d = i_funct3[1] ? i_in_a : '1;
                        state_d  = S_DONE;
                    end else if (ovf) begin
                        result_d = i_funct3[1] ? '0 : i_in_a;
                        state_d  = S_DONE;
                    end else if (small) begin
                        result_d = i_funct3[1] ? i_in_a : '0;
                        state_d  = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                rem_d = rem_it;
                quo_d = quo_it;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d    = '0;
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // Request is ignored here; a held i_md_en restarts next cycle.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge i_clk_n) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            result_q  <= '0;
            rem_sel_q <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            result_q  <= result_d;
            rem_sel_q <= rem_sel_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
        end
    end

    assign o_busy   = ~i_rst & (((state_q == S_IDLE) & start) | (state_q == S_RUN));
    assign o_result = result_q;

endmodule

// File: tb/tb_serial_divider.sv
// ---------------------------------------------------------------------------
// tb_serial_divider
//   Self-checking bench for serial_divider (WIDTH=32). Inputs change on the
//   rising edge of i_clk_n and outputs are sampled 1 time unit later, away
//   from the active falling edge. Expected results come from a behavioural
//   reference using SV division and are queued when an op is launched.
// ---------------------------------------------------------------------------
module tb_serial_divider;
    logic        i_clk_n = 1'b1;
    logic        i_rst;
    logic [31:0] i_in_a;
    logic [31:0] i_in_b;
    logic [2:0]  i_funct3;
    logic        i_md_en;
    logic        o_busy;
    logic [31:0] o_result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] prev_res;

    serial_divider #(.WIDTH(32)) dut (
        .i_clk_n  (i_clk_n),
        .i_rst    (i_rst),
        .i_in_a   (i_in_a),
        .i_in_b   (i_in_b),
        .i_funct3 (i_funct3),
        .i_md_en  (i_md_en),
        .o_busy   (o_busy),
        .o_result (o_result)
    );

    always #5 i_clk_n = ~i_clk_n;

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3[1:0])
            2'b00:   ref_res = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            2'b01:   ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10:   ref_res = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: ref_res = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_busy(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_EN
        logic [31:0] aa, ab;
        logic sgn;
        sgn = ~f3[0];
        aa  = (sgn && a[31]) ? (~a + 32'd1) : a;
        ab  = (sgn && b[31]) ? (~b + 32'd1) : b;
        if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || aa < ab)
            ref_busy = 1;
        else
            ref_busy = 33;
`else
        ref_busy = 33;
`endif
    endfunction

    // Launch one op, count busy cycles, compare result in the DONE cycle.
    // Returns in the DONE cycle with i_md_en still high.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string name);
        int          busy_n;
        int          exp_busy;
        logic        hold_bad;
        logic [31:0] exp;
        sb_q.push_back(ref_res(f3, a, b));
        exp_busy = ref_busy(f3, a, b);
        @(posedge i_clk_n);
        i_funct3 = f3;
        i_in_a   = a;
        i_in_b   = b;
        i_md_en  = 1'b1;
        #1;
        busy_n   = 0;
        hold_bad = 1'b0;
        while (o_busy === 1'b1 && busy_n < 200) begin
            if (o_result !== prev_res) hold_bad = 1'b1;
            busy_n++;
            @(posedge i_clk_n);
            #1;
        end
        exp = sb_q.pop_front();
        checks++;
        if (busy_n != exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_busy);
        end
        checks++;
        if (hold_bad) begin
            errors++;
            $display("FAIL %s result_hold: o_result changed while busy, expected %h", name, prev_res);
        end
        checks++;
        if (o_result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, o_result, exp);
        end
        prev_res = exp;
    endtask

    task automatic go_idle();
        @(posedge i_clk_n);
        i_md_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst    = 1'b1;
        i_md_en  = 1'b1;
        i_funct3 = 3'b100;
        i_in_a   = 32'd10;
        i_in_b   = 32'd3;
        repeat (2) @(posedge i_clk_n);
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", o_busy);
        end
        checks++;
        if (o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", o_result);
        end
        @(posedge i_clk_n);
        i_md_en = 1'b0;
        i_rst   = 1'b0;
        #1;
        prev_res = 32'h0;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_basic();
        run_op(3'b100, 32'd100, 32'd7, "div_100_7");
        go_idle();
        checks++;
        if (o_busy !== 1'b0 || o_result !== 32'd14) begin
            errors++;
            $display("FAIL after_done: busy %b result %h expected 0 / 0000000e", o_busy, o_result);
        end
    endtask

    task automatic test_signs();
        run_op(3'b110, 32'hFFFF_FF9C, 32'd7, "rem_m100_7");
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
        run_op(3'b101, 32'hFFFF_FFFF, 32'd2, "divu_max_2");
        run_op(3'b111, 32'hFFFF_FFFF, 32'd2, "remu_max_2");
        run_op(3'b100, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
        go_idle();
    endtask

    task automatic test_special();
        run_op(3'b100, 32'd5, 32'd0, "div_by_zero");
        run_op(3'b110, 32'd5, 32'd0, "rem_by_zero");
        run_op(3'b110, 32'hFFFF_FFFB, 32'd0, "rem_neg_by_zero");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
        run_op(3'b110, 32'hFFFF_FFFD, 32'd7, "rem_small");
        run_op(3'b101, 32'd3, 32'd70, "divu_small");
        go_idle();
    endtask

    task automatic test_reset_mid_run();
        @(posedge i_clk_n);
        i_funct3 = 3'b100;
        i_in_a   = 32'd1000;
        i_in_b   = 32'd7;
        i_md_en  = 1'b1;
        repeat (11) @(posedge i_clk_n);
        i_rst = 1'b1;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_run_busy: got %b expected 0", o_busy);
        end
        @(posedge i_clk_n);
        i_rst   = 1'b0;
        i_md_en = 1'b0;
        #1;
        prev_res = 32'h0;
        checks++;
        if (o_busy !== 1'b0 || o_result !== 32'h0) begin
            errors++;
            $display("FAIL rst_run_after: busy %b result %h expected 0 / 00000000", o_busy, o_result);
        end
        run_op(3'b100, 32'd9, 32'd3, "div_9_3_after_rst");
        go_idle();
    endtask

    task automatic test_back_to_back();
        run_op(3'b100, 32'd100, 32'd7, "b2b_first");
        i_in_a = 32'd81;
        i_in_b = 32'd9;
        #1;
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_ignores: busy %b expected 0", o_busy);
        end
        run_op(3'b100, 32'd81, 32'd9, "b2b_second");
        go_idle();
    endtask

    task automatic test_nondiv();
        @(posedge i_clk_n);
        i_funct3 = 3'b000;
        i_in_a   = 32'd55;
        i_in_b   = 32'd5;
        i_md_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (o_busy !== 1'b0 || o_result !== prev_res) begin
                errors++;
                $display("FAIL nondiv_%0d: busy %b result %h expected 0 / %h", i, o_busy, o_result, prev_res);
            end
            @(posedge i_clk_n);
        end
        i_md_en = 1'b0;
        #1;
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            f3 = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom;
            if (i == 0) b = 32'hFFFF_FFFF;
            run_op(f3, a, b, $sformatf("rand_%0d", i));
        end
        go_idle();
    endtask

    initial begin
        i_rst    = 1'b1;
        i_in_a   = '0;
        i_in_b   = '0;
        i_funct3 = '0;
        i_md_en  = 1'b0;
        prev_res = '0;
        test_reset();
        test_basic();
        test_signs();
        test_special();
        test_reset_mid_run();
        test_back_to_back();
        test_nondiv();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
